alu_multicycle: RTL

//   Parametrised successor to the 16-bit combinational ALU. Adds XOR, shifts, an iterative

---
 rtl/alu_multicycle.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Parametrised ALU with valid/ready handshake; iterative shift-add MUL and restoring DIVU/REMU.
// Latency: result_valid 1 edge after accept (ops 0-7, div-by-zero, reserved), WIDTH+1 edges for MUL/DIVU/REMU.
// Backpressure: one op in flight; Result/flags hold in DONE until result_ready, in_ready only in IDLE.
module alu_multicycle #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   ALUOp,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);

    // EXEC is the single transitional cycle between accept and DONE for one-cycle ops
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(9);
    localparam logic [OPW-1:0] OP_REMU = OPW'(10);

    localparam logic [WIDTH-1:0] W_L      = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic             in_rdy_q, in_rdy_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // rem_q/quo_q double as {product hi, product lo} for MUL and {remainder, quotient} for DIV
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d, dz_q, dz_d;

    logic [WIDTH:0]   add_w, sub_w, mul_sum, div_sh, div_df;
    logic [WIDTH-1:0] sc_r, fin_r;
    logic             sc_c, sc_v, sc_dz, sh_ok;

    assign add_w   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w   = {1'b0, a_q} - {1'b0, b_q};
    assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, a_q} : '0);
    assign div_sh  = {rem_q, quo_q[WIDTH-1]};
    assign div_df  = div_sh - {1'b0, b_q};
    // shift carry exists only for amounts 1..WIDTH
    assign sh_ok   = (b_q != '0) && (b_q <= W_L);

    // Single-cycle result and flags from the latched operands
    always_comb begin
        sc_r  = '0;
        sc_c  = 1'b0;
        sc_v  = 1'b0;
        sc_dz = 1'b0;
        case (op_q)
            OP_ADD: begin
                sc_r = add_w[WIDTH-1:0];
                sc_c = add_w[WIDTH];
                sc_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sc_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sc_r = sub_w[WIDTH-1:0];
                sc_c = sub_w[WIDTH];
                sc_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sc_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: sc_r = a_q & b_q;
            OP_OR:  sc_r = a_q | b_q;
            OP_NOT: sc_r = ~a_q;
            OP_XOR: sc_r = a_q ^ b_q;
            OP_SHL: begin
                sc_r = a_q << b_q;
                sc_c = sh_ok && (|(a_q & (W_ONE << (W_L - b_q))));
            end
            OP_SHR: begin
                sc_r = a_q >> b_q;
                sc_c = sh_ok && (|(a_q & (W_ONE << (b_q - W_ONE))));
            end
            // only reached here with a zero divisor
            OP_DIVU: begin
                sc_r  = '1;
                sc_dz = 1'b1;
            end
            OP_REMU: begin
                sc_r  = a_q;
                sc_dz = 1'b1;
            end
            default: sc_r = '0;
        endcase
    end

    // Control FSM, operand capture, iteration datapath and result/flag update
    always_comb begin
        state_d = state_q;
        in_rdy_d = in_rdy_q;
        vld_d   = vld_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        fin_r   = (op_q == OP_REMU) ? rem_q : quo_q;
        case (state_q)
            S_IDLE: begin
                in_rdy_d = 1'b1;
                if (in_valid && in_rdy_q) begin
                    a_d      = A;
                    b_d      = B;
                    op_d     = ALUOp;
                    cnt_d    = '0;
                    in_rdy_d = 1'b0;
                    if ((ALUOp == OP_MUL) ||
                        (((ALUOp == OP_DIVU) || (ALUOp == OP_REMU)) && (B != '0))) begin
                        state_d = S_BUSY;
                        rem_d   = '0;
                        quo_d   = (ALUOp == OP_MUL) ? B : A;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                res_d   = sc_r;
                zero_d  = (sc_r == '0);
                neg_d   = sc_r[WIDTH-1];
                carry_d = sc_c;
                ovf_d   = sc_v;
                dz_d    = sc_dz;
                vld_d   = 1'b1;
                state_d = S_DONE;
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    res_d   = fin_r;
                    zero_d  = (fin_r == '0);
                    neg_d   = fin_r[WIDTH-1];
                    carry_d = (op_q == OP_MUL) && (|rem_q);
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q == OP_MUL) begin
                        rem_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end else if (!div_df[WIDTH]) begin
                        rem_d = div_df[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                if (result_ready) begin
                    vld_d    = 1'b0;
                    in_rdy_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // State registers; reset aborts any op in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            in_rdy_q <= 1'b0;
            vld_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= in_rdy_d;
            vld_q    <= vld_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready     = in_rdy_q;
    assign result_valid = vld_q;
    assign Result       = res_q;
    assign Zero         = zero_q;
    assign Carry        = carry_q;
    assign Overflow     = ovf_q;
    assign Negative     = neg_q;
    assign DivZero      = dz_q;
endmodule
